// File: rtl/sdram_write_buffer_pkg.sv
// Shared types and constants for the ping-pong SDRAM write buffer.
// Bank lifecycle encoding and the packed {mask, data} storage word.
package sdram_write_buffer_pkg;

  typedef enum logic [1:0] {
    WBUF_EMPTY   = 2'd0,
    WBUF_FILLING = 2'd1,
    WBUF_READY   = 2'd2,
    WBUF_ACTIVE  = 2'd3
  } wbuf_state_e;

  localparam int WBUF_WIDTH = 36;
  localparam int SIZE_W     = 24;

  // The engine wants a write mask, so byte enables are stored inverted.
  function automatic logic [WBUF_WIDTH-1:0] pack_word(input logic [31:0] data,
                                                      input logic [3:0]  byte_en);
    return {~byte_en, data};
  endfunction

endpackage

// File: rtl/sdram_write_buffer_ram.sv
// Two-bank word store: synchronous write, asynchronous read.
// Address MSB selects the bank, low bits index the word inside it.
module sdram_wbuf_ram
  import sdram_write_buffer_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [WBUF_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [WBUF_WIDTH-1:0] rd_data
);

  logic [WBUF_WIDTH-1:0] mem_q [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sdram_write_buffer.sv
// Ping-pong write buffer: one bank fills from the bus while the other is
// drained by the SDRAM write engine, banks handed over in commit order.
module sdram_write_buffer
  import sdram_write_buffer_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_strobe,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_byte_en,
  input  logic                  wr_flush,
  output logic                  wr_ready,
  output logic                  overflow,
  output logic                  empty,
  output logic                  fifo_ready,
  input  logic                  fifo_activate,
  output logic [SIZE_W-1:0]     fifo_size,
  input  logic                  fifo_read,
  output logic [WBUF_WIDTH-1:0] fifo_data
);

  localparam int               CNT_W    = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wbuf_state_e           state_q [2];
  wbuf_state_e           state_d [2];
  logic [CNT_W-1:0]      count_q [2];
  logic [CNT_W-1:0]      count_d [2];
  logic                  fill_sel_q, fill_sel_d;
  logic                  drain_sel_q, drain_sel_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE_W-1:0]     size_q, size_d;
  logic                  overflow_q, overflow_d;
  logic                  act_q, act_d;

  logic                  fill_open, drain_ready, drain_active, any_active;
  logic                  wr_accept, act_rise, act_fall, rd_last, rd_adv, commit;
  logic [CNT_W-1:0]      fill_cnt_next;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [WBUF_WIDTH-1:0] ram_rd_data;

  assign fill_open     = (state_q[fill_sel_q] == WBUF_EMPTY) ||
                         (state_q[fill_sel_q] == WBUF_FILLING);
  assign drain_ready   = (state_q[drain_sel_q] == WBUF_READY);
  assign drain_active  = (state_q[drain_sel_q] == WBUF_ACTIVE);
  assign any_active    = (state_q[0] == WBUF_ACTIVE) || (state_q[1] == WBUF_ACTIVE);
  assign wr_accept     = wr_strobe && fill_open;
  assign fill_cnt_next = count_q[fill_sel_q] + CNT_W'(wr_accept);
  // Last-slot write with flush lands here once: both terms select the same commit.
  assign commit        = fill_open &&
                         ((fill_cnt_next == FULL_CNT) || (wr_flush && (fill_cnt_next != '0)));
  assign act_rise      = fifo_activate && !act_q;
  assign act_fall      = !fifo_activate && act_q;
  assign rd_last       = (({1'b0, rd_ptr_q} + CNT_W'(1)) == count_q[drain_sel_q]);
  assign rd_adv        = fifo_read && drain_active && !rd_last;
  assign rd_idx        = rd_adv ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
  assign act_d         = fifo_activate;

  sdram_wbuf_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr ({fill_sel_q, count_q[fill_sel_q][ADDR_WIDTH-1:0]}),
    .wr_data (pack_word(wr_data, wr_byte_en)),
    .rd_addr ({drain_sel_q, rd_idx}),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]  <= WBUF_EMPTY;
      state_q[1]  <= WBUF_EMPTY;
      count_q[0]  <= '0;
      count_q[1]  <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      rd_ptr_q    <= '0;
      size_q      <= '0;
      overflow_q  <= 1'b0;
      act_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      rd_ptr_q    <= rd_ptr_d;
      size_q      <= size_d;
      overflow_q  <= overflow_d;
      act_q       <= act_d;
    end
  end

  // Fill and drain never touch the same bank: fill needs EMPTY/FILLING, drain READY/ACTIVE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    rd_ptr_d    = rd_ptr_q;
    size_d      = size_q;
    overflow_d  = overflow_q || (wr_strobe && !fill_open);

    if (wr_accept) begin
      count_d[fill_sel_q] = fill_cnt_next;
      state_d[fill_sel_q] = WBUF_FILLING;
    end
    if (commit) begin
      state_d[fill_sel_q] = WBUF_READY;
      fill_sel_d          = ~fill_sel_q;
    end

    if (act_rise && drain_ready) begin
      state_d[drain_sel_q] = WBUF_ACTIVE;
      size_d               = SIZE_W'(count_q[drain_sel_q]);
    end else if (act_fall && drain_active) begin
      state_d[drain_sel_q] = WBUF_EMPTY;
      count_d[drain_sel_q] = '0;
      rd_ptr_d             = '0;
      size_d               = '0;
      drain_sel_d          = ~drain_sel_q;
    end else begin
      rd_ptr_d = rd_idx;
    end
  end

  always_comb begin
    wr_ready   = fill_open;
    overflow   = overflow_q;
    empty      = (state_q[0] == WBUF_EMPTY) && (state_q[1] == WBUF_EMPTY);
    fifo_ready = drain_ready && !fifo_activate && !any_active;
    fifo_size  = '0;
    fifo_data  = '0;
    if (drain_active) begin
      fifo_size = size_q;
      fifo_data = ram_rd_data;
    end else if (drain_ready) begin
      fifo_size = SIZE_W'(count_q[drain_sel_q]);
      fifo_data = ram_rd_data;
    end
  end

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed bench for the ping-pong write buffer with hand-computed expectations.
module tb_sdram_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_strobe;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        wr_flush;
  logic        wr_ready;
  logic        overflow;
  logic        empty;
  logic        fifo_ready;
  logic        fifo_activate;
  logic [23:0] fifo_size;
  logic        fifo_read;
  logic [35:0] fifo_data;

  int checks = 0;
  int errors = 0;
  logic ready_all;

  always #5 clk = ~clk;

  sdram_write_buffer #(.DEPTH(128), .ADDR_WIDTH(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_strobe     (wr_strobe),
    .wr_data       (wr_data),
    .wr_byte_en    (wr_byte_en),
    .wr_flush      (wr_flush),
    .wr_ready      (wr_ready),
    .overflow      (overflow),
    .empty         (empty),
    .fifo_ready    (fifo_ready),
    .fifo_activate (fifo_activate),
    .fifo_size     (fifo_size),
    .fifo_read     (fifo_read),
    .fifo_data     (fifo_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d, input logic [3:0] en, input logic flush);
    wr_strobe  = 1'b1;
    wr_data    = d;
    wr_byte_en = en;
    wr_flush   = flush;
    tick();
    wr_strobe  = 1'b0;
    wr_flush   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_strobe = 1'b0; wr_data = '0; wr_byte_en = '0; wr_flush = 1'b0;
    fifo_activate = 1'b0; fifo_read = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_empty", empty, 1);
    chk("rst_fifo_ready", fifo_ready, 0);
    chk("rst_fifo_size", fifo_size, 0);
    chk("rst_fifo_data", fifo_data, 0);

    // Five words then flush
    for (int i = 1; i <= 5; i++) write_word(32'h11111111 * i, 4'hF, 1'b0);
    chk("t1_not_ready_before_flush", fifo_ready, 0);
    wr_flush = 1'b1; tick(); wr_flush = 1'b0;
    chk("t1_fifo_ready", fifo_ready, 1);
    chk("t1_fifo_size", fifo_size, 5);
    chk("t1_empty", empty, 0);
    chk("t1_word0", fifo_data, 36'h0_11111111);
    fifo_activate = 1'b1; #1;
    chk("t1_ready_drops_on_activate", fifo_ready, 0);
    tick();
    chk("t1_active_size", fifo_size, 5);
    for (int k = 1; k <= 4; k++) begin
      fifo_read = 1'b1; #1;
      chk("t1_read_lookahead", fifo_data, {4'h0, 32'h11111111 * (k + 1)});
      tick();
      fifo_read = 1'b0;
    end
    fifo_read = 1'b1; #1;
    chk("t1_last_word_hold", fifo_data, 36'h0_55555555);
    tick(); fifo_read = 1'b0;
    fifo_activate = 1'b0; tick();
    chk("t1_release_empty", empty, 1);
    chk("t1_release_size", fifo_size, 0);
    chk("t1_release_data", fifo_data, 0);

    // Byte-enable mask inversion, written with flush in the same cycle
    write_word(32'hA5A5A5A5, 4'b0101, 1'b1);
    chk("t3_fifo_ready", fifo_ready, 1);
    chk("t3_fifo_size", fifo_size, 1);
    chk("t3_mask_data", fifo_data, 36'hA_A5A5A5A5);
    fifo_activate = 1'b1; tick();
    fifo_activate = 1'b0; tick();
    chk("t3_empty_after_release", empty, 1);

    // Flush with nothing written is ignored
    wr_flush = 1'b1; tick(); wr_flush = 1'b0;
    chk("t4_flush_empty_empty", empty, 1);
    chk("t4_flush_empty_ready", fifo_ready, 0);
    chk("t4_flush_empty_wr_ready", wr_ready, 1);

    // Flush on the DEPTH-th write commits exactly once
    for (int i = 0; i < 127; i++) write_word(32'h10000000 + i, 4'hF, 1'b0);
    write_word(32'h1000007F, 4'hF, 1'b1);
    chk("t4_full_flush_ready", fifo_ready, 1);
    chk("t4_full_flush_size", fifo_size, 128);
    chk("t4_full_flush_wr_ready", wr_ready, 1);
    fifo_activate = 1'b1; tick();
    chk("t4_word0", fifo_data, 36'h0_10000000);
    fifo_activate = 1'b0; tick();
    chk("t4_single_commit_empty", empty, 1);
    chk("t4_single_commit_ready", fifo_ready, 0);

    // 256 writes without flush fill both banks via auto commit
    ready_all = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ready_all = ready_all & wr_ready;
      write_word(32'h20000000 + i, 4'hF, 1'b0);
    end
    chk("t2_auto_commit_ready", fifo_ready, 1);
    chk("t2_auto_commit_size", fifo_size, 128);
    for (int i = 0; i < 128; i++) begin
      ready_all = ready_all & wr_ready;
      write_word(32'h30000000 + i, 4'hF, 1'b0);
    end
    chk("t2_wr_ready_held", ready_all, 1);
    chk("t2_full_wr_ready", wr_ready, 0);
    chk("t2_no_overflow_yet", overflow, 0);
    write_word(32'hDEADBEEF, 4'hF, 1'b0);
    chk("t2_overflow", overflow, 1);
    chk("t2_size_unchanged", fifo_size, 128);

    // Release after two reads; the second bank is offered next
    fifo_activate = 1'b1; tick();
    chk("t5_word0", fifo_data, 36'h0_20000000);
    for (int k = 1; k <= 2; k++) begin
      fifo_read = 1'b1; #1;
      chk("t5_read", fifo_data, {4'h0, 32'h20000000 + k});
      tick();
      fifo_read = 1'b0;
    end
    fifo_activate = 1'b0; tick();
    chk("t5_wr_ready_after_release", wr_ready, 1);
    chk("t5_next_bank_ready", fifo_ready, 1);
    chk("t5_next_bank_size", fifo_size, 128);
    chk("t5_next_bank_word0", fifo_data, 36'h0_30000000);
    chk("t5_overflow_sticky", overflow, 1);

    // Write to the freed bank, then release and commit in the same cycle
    write_word(32'h40000000, 4'hF, 1'b0);
    fifo_activate = 1'b1; tick();
    fifo_read = 1'b1; #1;
    chk("t5_second_bank_read", fifo_data, 36'h0_30000001);
    tick(); fifo_read = 1'b0;
    fifo_activate = 1'b0; wr_flush = 1'b1; tick(); wr_flush = 1'b0;
    chk("sim_commit_release_ready", fifo_ready, 1);
    chk("sim_commit_release_size", fifo_size, 1);
    chk("sim_commit_release_data", fifo_data, 36'h0_40000000);
    chk("sim_commit_release_wr_ready", wr_ready, 1);

    // Reset while one bank is ACTIVE and the other FILLING
    write_word(32'h50000000, 4'hF, 1'b0);
    fifo_activate = 1'b1; tick();
    chk("t6_active_size", fifo_size, 1);
    chk("t6_active_not_empty", empty, 0);
    rst = 1'b1; fifo_activate = 1'b0; tick();
    chk("t6_rst_wr_ready", wr_ready, 1);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_fifo_ready", fifo_ready, 0);
    chk("t6_rst_fifo_size", fifo_size, 0);
    chk("t6_rst_fifo_data", fifo_data, 0);
    rst = 1'b0; tick();
    chk("t6_post_rst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
